cpu_regwrite_arbiter: RTL and testbench

Shares the register file's two write ports among three writeback requesters: ALU writeback, load-return and special/exception writes.
- Each cycle, grants up to two requests using a rotating-priority (round-robin) pointer.
- Registers the selected writes one cycle before driving the register file's write ports.
- Keeps a 16-entry busy scoreboard so decode can stall on registers that still have a pending write.

---
 rtl/cpu_regwrite_arbiter.sv | 126 ++++++++++++
 tb/tb_cpu_regwrite_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cpu_regwrite_arbiter.sv
// Register-file write-port arbiter: three writeback requesters share two write ports
// via a rotating pointer, with a busy scoreboard. Optional bypass outputs: REGARB_BYPASS_EN.
module cpu_regwrite_arbiter #(
   parameter int NUM_REGS = 16,
   parameter int RR_INIT  = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [2:0]          req_i,
   input  logic [3:0]          idx0_i,
   input  logic [3:0]          idx1_i,
   input  logic [3:0]          idx2_i,
   input  logic [31:0]         data0_i,
   input  logic [31:0]         data1_i,
   input  logic [31:0]         data2_i,
   output logic [2:0]          grant_o,
   input  logic                reserve_i,
   input  logic [3:0]          reserve_idx_i,
   output logic [NUM_REGS-1:0] busy_o,
`ifdef REGARB_BYPASS_EN
   output logic [1:0]          fwd_valid_o,
   output logic [3:0]          fwd_idx0_o,
   output logic [3:0]          fwd_idx1_o,
   output logic [31:0]         fwd_data0_o,
   output logic [31:0]         fwd_data1_o,
`endif
   output logic                write_enable0_o,
   output logic                write_enable1_o,
   output logic [3:0]          reg_write_index0_o,
   output logic [3:0]          reg_write_index1_o,
   output logic [31:0]         value0_o,
   output logic [31:0]         value1_o
);

   logic [3:0]          w_idx  [3];
   logic [31:0]         w_data [3];
   logic [1:0]          r_ptr;
   logic [1:0]          w_ptr_nxt;
   logic [2:0]          w_sum;
   logic [1:0]          w_ord;
   logic                w_v0, w_v1;
   logic [1:0]          w_sel0, w_sel1, w_last;
   logic [2:0]          w_grant;
   logic [NUM_REGS-1:0] w_clr, w_set;
   logic [NUM_REGS-1:0] r_busy;

   assign w_idx[0]  = idx0_i;
   assign w_idx[1]  = idx1_i;
   assign w_idx[2]  = idx2_i;
   assign w_data[0] = data0_i;
   assign w_data[1] = data1_i;
   assign w_data[2] = data2_i;

   // Scan from the pointer; a candidate colliding with port 0's index is skipped,
   // so port 1 may fall through to the third requester.
   always_comb begin
      w_v0    = 1'b0;
      w_v1    = 1'b0;
      w_sel0  = 2'd0;
      w_sel1  = 2'd0;
      w_sum   = 3'd0;
      w_ord   = 2'd0;
      for (int k = 0; k < 3; k++) begin
         w_sum = {1'b0, r_ptr} + 3'(k);
         w_ord = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
         if (req_i[w_ord] && !rst_i) begin
            if (!w_v0) begin
               w_v0   = 1'b1;
               w_sel0 = w_ord;
            end else if (!w_v1 && (w_idx[w_ord] != w_idx[w_sel0])) begin
               w_v1   = 1'b1;
               w_sel1 = w_ord;
            end
         end
      end
      w_grant = 3'b000;
      if (w_v0) w_grant[w_sel0] = 1'b1;
      if (w_v1) w_grant[w_sel1] = 1'b1;
      w_last    = w_v1 ? w_sel1 : w_sel0;
      w_ptr_nxt = (w_last == 2'd2) ? 2'd0 : w_last + 2'd1;
   end

   assign grant_o = w_grant;

   always_comb begin
      w_clr = '0;
      w_set = '0;
      if (w_v0)      w_clr[w_idx[w_sel0]] = 1'b1;
      if (w_v1)      w_clr[w_idx[w_sel1]] = 1'b1;
      if (reserve_i) w_set[reserve_idx_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr              <= 2'(RR_INIT);
         r_busy             <= '0;
         write_enable0_o    <= 1'b0;
         write_enable1_o    <= 1'b0;
         reg_write_index0_o <= 4'd0;
         reg_write_index1_o <= 4'd0;
         value0_o           <= 32'd0;
         value1_o           <= 32'd0;
      end else begin
         if (w_v0) r_ptr <= w_ptr_nxt;
         // Set after clear: a same-cycle reserve keeps the bit busy.
         r_busy             <= (r_busy & ~w_clr) | w_set;
         write_enable0_o    <= w_v0;
         write_enable1_o    <= w_v1;
         reg_write_index0_o <= w_v0 ? w_idx[w_sel0]  : 4'd0;
         reg_write_index1_o <= w_v1 ? w_idx[w_sel1]  : 4'd0;
         value0_o           <= w_v0 ? w_data[w_sel0] : 32'd0;
         value1_o           <= w_v1 ? w_data[w_sel1] : 32'd0;
      end
   end

   assign busy_o = r_busy;

`ifdef REGARB_BYPASS_EN
   assign fwd_valid_o = {w_v1, w_v0};
   assign fwd_idx0_o  = w_v0 ? w_idx[w_sel0]  : 4'd0;
   assign fwd_idx1_o  = w_v1 ? w_idx[w_sel1]  : 4'd0;
   assign fwd_data0_o = w_v0 ? w_data[w_sel0] : 32'd0;
   assign fwd_data1_o = w_v1 ? w_data[w_sel1] : 32'd0;
`endif

endmodule

// File: tb/tb_cpu_regwrite_arbiter.sv
// Directed bench for cpu_regwrite_arbiter: arbitration order, index conflicts,
// latency, scoreboard set/clear priority and mid-operation reset.
module tb_cpu_regwrite_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [3:0]  idx0, idx1, idx2, ridx;
   logic [31:0] d0, d1, d2;
   logic        rsv;
   logic [2:0]  grant;
   logic [15:0] busy;
   logic        we0, we1;
   logic [3:0]  wi0, wi1;
   logic [31:0] v0, v1;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cpu_regwrite_arbiter #(.NUM_REGS(16), .RR_INIT(0)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req),
      .idx0_i(idx0), .idx1_i(idx1), .idx2_i(idx2),
      .data0_i(d0), .data1_i(d1), .data2_i(d2),
      .grant_o(grant), .reserve_i(rsv), .reserve_idx_i(ridx), .busy_o(busy),
      .write_enable0_o(we0), .write_enable1_o(we1),
      .reg_write_index0_o(wi0), .reg_write_index1_o(wi1),
      .value0_o(v0), .value1_o(v1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr0(input logic [3:0] i, input logic [31:0] d);
      chk("we0", 32'(we0), 1); chk("wi0", 32'(wi0), 32'(i)); chk("v0", v0, d);
   endtask

   task automatic wr1(input logic [3:0] i, input logic [31:0] d);
      chk("we1", 32'(we1), 1); chk("wi1", 32'(wi1), 32'(i)); chk("v1", v1, d);
   endtask

   task automatic pulse_reset();
      rst = 1'b1; req = 3'b000; rsv = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 3'b111; rsv = 1'b0; ridx = 4'd0;
      idx0 = 4'd0; idx1 = 4'd1; idx2 = 4'd2; d0 = '0; d1 = '0; d2 = '0;
      #1;
      chk("grant_in_rst", 32'(grant), 0);
      tick(); tick();
      chk("rst_we0", 32'(we0), 0); chk("rst_we1", 32'(we1), 0);
      chk("rst_busy", 32'(busy), 0); chk("rst_v0", v0, 0);
      rst = 1'b0; req = 3'b000;
      #1;
      chk("idle_grant", 32'(grant), 0);

      // single request, pointer 0 -> 1
      req = 3'b001; idx0 = 4'd3; d0 = 32'hDEADBEEF;
      #1; chk("single_grant", 32'(grant), 3'b001);
      tick(); req = 3'b000;
      wr0(4'd3, 32'hDEADBEEF); chk("single_we1", 32'(we1), 0);
      tick();
      chk("we0_one_cycle", 32'(we0), 0);

      // all three, distinct indices, pointer 0
      pulse_reset();
      req = 3'b111; idx0 = 4'd1; idx1 = 4'd2; idx2 = 4'd5;
      d0 = 32'hA1; d1 = 32'hA2; d2 = 32'hA5;
      #1; chk("rr_c1_grant", 32'(grant), 3'b011);
      tick();
      wr0(4'd1, 32'hA1); wr1(4'd2, 32'hA2);
      chk("rr_c2_grant", 32'(grant), 3'b101);   // pointer 2: scan 2,0,1
      tick(); req = 3'b000;
      wr0(4'd5, 32'hA5); wr1(4'd1, 32'hA1);

      // same index from two requesters, pointer 0
      pulse_reset();
      req = 3'b011; idx0 = 4'd7; idx1 = 4'd7; d0 = 32'hC0; d1 = 32'hC1;
      #1; chk("same_idx_grant", 32'(grant), 3'b001);
      tick(); req = 3'b010;
      wr0(4'd7, 32'hC0); chk("same_idx_we1", 32'(we1), 0);
      #1; chk("same_idx_next", 32'(grant), 3'b010);
      tick(); req = 3'b000;
      wr0(4'd7, 32'hC1);

      // pointer 2: first=2, requester 0 collides, port 1 falls to requester 1
      req = 3'b111; idx0 = 4'd4; idx1 = 4'd6; idx2 = 4'd4;
      d0 = 32'hD0; d1 = 32'hD1; d2 = 32'hD2;
      #1; chk("third_grant", 32'(grant), 3'b110);
      tick(); req = 3'b000;
      wr0(4'd4, 32'hD2); wr1(4'd6, 32'hD1);

      // scoreboard
      rsv = 1'b1; ridx = 4'd9;
      tick(); rsv = 1'b0;
      chk("busy_set", 32'(busy), 32'h0200);
      req = 3'b001; idx0 = 4'd9; d0 = 32'h99;
      tick(); req = 3'b000;
      chk("busy_clr", 32'(busy), 0);
      rsv = 1'b1;
      tick();
      req = 3'b001;
      tick(); req = 3'b000; rsv = 1'b0;
      chk("busy_rsv_wins", 32'(busy), 32'h0200);
      wr0(4'd9, 32'h99);

      // reset the cycle after a grant
      req = 3'b001; idx0 = 4'd2; d0 = 32'hE0;
      tick();
      rst = 1'b1; req = 3'b111;
      #1; chk("grant_mid_rst", 32'(grant), 0);
      tick();
      chk("mrst_we0", 32'(we0), 0); chk("mrst_we1", 32'(we1), 0);
      chk("mrst_busy", 32'(busy), 0);
      rst = 1'b0; req = 3'b011; idx0 = 4'd8; idx1 = 4'd8;
      #1; chk("ptr_after_rst", 32'(grant), 3'b001);
      tick(); req = 3'b000;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
